sram_arbiter: RTL

- Shares the single-port data SRAM between two requesters: port 0 (CPU load/store path) and port 1 (a test/loader master that preloads or dumps data memory).
- Sits between the requesters and the SRAM, and drives the SRAM enable/address/data pins.
- Arbitration is round-robin, with an optional bounded lock that gives one port back-to-back bursts.
- A one-stage read-return pipeline routes synchronous SRAM read data back to the port that issued the read.

---
 rtl/sram_arb_pkg.sv | 24 ++
 rtl/sram_arb_rdret.sv | 49 ++++
 rtl/sram_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the data-SRAM arbiter.
//   arb_state_t      : arbiter FSM states (free arbitration, port 0 locked, port 1 locked)
//   ADDR_W           : SRAM address width for the default RF_addressBits
//   addr_width()     : address width as a function of RF_addressBits
//   CPU_PORT/LDR_PORT: port indices (CPU load/store path, test/loader master)
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int RF_ADDRESS_BITS = 3;
  localparam int ADDR_W          = 2 ** RF_ADDRESS_BITS;

  localparam logic CPU_PORT = 1'b0;
  localparam logic LDR_PORT = 1'b1;

  function automatic int addr_width(input int rf_address_bits);
    return 2 ** rf_address_bits;
  endfunction

endpackage

// File: rtl/sram_arb_rdret.sv
// One-stage read-return path: remembers which port issued the read granted
// in the previous cycle and steers the synchronous SRAM read data to it.
//   clk, rst           : clock, asynchronous active-high reset
//   rd_issue, rd_port  : a read is granted this cycle, and to which port
//   sram_data          : SRAM read data (valid the cycle after the read)
//   rvalid0/1, rdata0/1: per-port read return; rdata is 0 when rvalid is low
module sram_arb_rdret
  import sram_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_issue,
  input  logic         rd_port,
  input  logic [N-1:0] sram_data,
  output logic         rvalid0,
  output logic         rvalid1,
  output logic [N-1:0] rdata0,
  output logic [N-1:0] rdata1
);

  logic rd_pend_q, rd_pend_d;
  logic rd_port_q, rd_port_d;

  always_comb begin
    rd_pend_d = rd_issue;
    rd_port_d = rd_issue ? rd_port : rd_port_q;
  end

  // Reset drops any read in flight so no stale rvalid appears afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_port_q <= CPU_PORT;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  always_comb begin
    rvalid0 = rd_pend_q && (rd_port_q == CPU_PORT);
    rvalid1 = rd_pend_q && (rd_port_q == LDR_PORT);
    rdata0  = rvalid0 ? sram_data : '0;
    rdata1  = rvalid1 ? sram_data : '0;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single-port data SRAM.
// Port 0 is the CPU load/store path, port 1 the test/loader master.
// Round-robin arbitration with an optional bounded lock (MAX_LOCK grants
// while the other port waits), combinational grant, one-cycle read return.
//   clk, rst                 : clock, asynchronous active-high reset
//   req/we/lock/addr/wdata 0,1 : per-port request
//   gnt0/1                   : access issued to the SRAM this cycle
//   rvalid0/1, rdata0/1      : read return, one cycle after the read grant
//   SRAM_*                   : SRAM pins
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int N              = 8,
  parameter  int RF_addressBits = 3,
  parameter  int MAX_LOCK       = 4,
  localparam int AW             = addr_width(RF_addressBits)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [N-1:0]  wdata0,
  input  logic [N-1:0]  wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [N-1:0]  rdata0,
  output logic [N-1:0]  rdata1,
  output logic          SRAM_readEnable,
  output logic          SRAM_writeEnable,
  output logic [AW-1:0] SRAM_address,
  output logic [N-1:0]  SRAM_data_in,
  input  logic [N-1:0]  SRAM_data
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;

  logic gnt_any;    // some port wins this cycle
  logic gnt_v;      // grant, suppressed while reset is asserted
  logic win;        // winning port index
  logic owner;      // port holding the lock (when locked)
  logic in_lock;    // locked and the owner is still requesting
  logic other_req;  // the non-owner is waiting
  logic cont;       // grant continues an existing lock
  logic win_lock;
  logic win_we;

  always_comb begin
    gnt_any    = 1'b0;
    win        = CPU_PORT;
    cont       = 1'b0;
    win_lock   = 1'b0;
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    owner      = (state_q == LOCK1) ? LDR_PORT : CPU_PORT;
    other_req  = (owner == LDR_PORT) ? req0 : req1;
    in_lock    = (state_q != IDLE) && ((owner == LDR_PORT) ? req1 : req0);

    if (in_lock) begin
      if (other_req && (lock_cnt_q == MAX_CNT)) begin
        // Lock budget spent: idle one cycle and hand the tie to the waiter.
        state_d    = IDLE;
        last_d     = owner;
        lock_cnt_d = '0;
      end else begin
        gnt_any = 1'b1;
        win     = owner;
        cont    = 1'b1;
      end
    end else begin
      // Free arbitration; also covers a lock whose owner has let go.
      state_d    = IDLE;
      lock_cnt_d = '0;
      if (req0 && req1) begin
        gnt_any = 1'b1;
        win     = ~last_q;
      end else if (req0) begin
        gnt_any = 1'b1;
        win     = CPU_PORT;
      end else if (req1) begin
        gnt_any = 1'b1;
        win     = LDR_PORT;
      end
    end

    if (gnt_any) begin
      last_d   = win;
      win_lock = (win == LDR_PORT) ? lock1 : lock0;
      if (!win_lock) begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end else begin
        state_d = (win == LDR_PORT) ? LOCK1 : LOCK0;
        if (!cont)
          lock_cnt_d = 4'd1;
        else if (other_req)
          lock_cnt_d = (lock_cnt_q == MAX_CNT) ? MAX_CNT : lock_cnt_q + 4'd1;
        else
          lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= LDR_PORT;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Grant and SRAM pins are combinational from the winner; held quiet in reset.
  always_comb begin
    gnt_v            = gnt_any && !rst;
    win_we           = (win == LDR_PORT) ? we1 : we0;
    gnt0             = gnt_v && (win == CPU_PORT);
    gnt1             = gnt_v && (win == LDR_PORT);
    SRAM_readEnable  = gnt_v && !win_we;
    SRAM_writeEnable = gnt_v && win_we;
    SRAM_address     = '0;
    SRAM_data_in     = '0;
    if (gnt_v) begin
      SRAM_address = (win == LDR_PORT) ? addr1 : addr0;
      SRAM_data_in = (win == LDR_PORT) ? wdata1 : wdata0;
    end
  end

  sram_arb_rdret #(.N(N)) u_rdret (
    .clk       (clk),
    .rst       (rst),
    .rd_issue  (SRAM_readEnable),
    .rd_port   (win),
    .sram_data (SRAM_data),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1)
  );

endmodule
